// File: rtl/comp_seq_pkg.sv
// comp_seq_pkg: shared types and constants for the sequential comparator controller
package comp_seq_pkg;
  localparam int SLICE_W = 2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} comp_state_e;
endpackage

// File: rtl/comp_seq_ctrl_comp_2bit.sv
// COMP_2bit: combinational 2-bit unsigned magnitude compare (the shared slice resource)
//   i_a, i_b : slice operands
//   o_less   : i_a < i_b
//   o_equal  : i_a == i_b
module COMP_2bit
  import comp_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  output logic               o_less,
  output logic               o_equal
);
  assign o_less  = i_a < i_b;
  assign o_equal = i_a == i_b;
endmodule

// File: rtl/comp_seq_ctrl.sv
// comp_seq_ctrl: MSB-first sequential magnitude compare using one shared 2-bit slice comparator
//   i_start_valid/o_start_ready, i_data_a/i_data_b : operand pair handshake (accepted in IDLE only)
//   o_done_valid/i_done_ready                      : result handshake, verdict held while waiting
//   o_less/o_equal/o_greater, o_slices             : registered verdict and slices examined
//   o_busy                                         : state is not IDLE
module comp_seq_ctrl
  import comp_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int NSLICE = DATA_WIDTH / SLICE_W,
  localparam int IW     = $clog2(NSLICE),
  localparam int CW     = IW + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start_valid,
  output logic                  o_start_ready,
  input  logic [DATA_WIDTH-1:0] i_data_a,
  input  logic [DATA_WIDTH-1:0] i_data_b,
  output logic                  o_done_valid,
  input  logic                  i_done_ready,
  output logic                  o_less,
  output logic                  o_equal,
  output logic                  o_greater,
  output logic [CW-1:0]         o_slices,
  output logic                  o_busy
);
  if (DATA_WIDTH % 2 != 0 || DATA_WIDTH < 4) begin : g_bad_width
    $error("comp_seq_ctrl: DATA_WIDTH must be even and >= 4");
  end
  comp_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  dec_q, dec_d, less_q, less_d, equal_q, equal_d, greater_q, greater_d, done_q, done_d;
  logic                  c_less, c_equal;
  COMP_2bit u_comp (
    .i_a     (a_q[SLICE_W*idx_q +: SLICE_W]),
    .i_b     (b_q[SLICE_W*idx_q +: SLICE_W]),
    .o_less  (c_less),
    .o_equal (c_equal)
  );
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dec_d     = dec_q;
    less_d    = less_q;
    equal_d   = equal_q;
    greater_d = greater_q;
    done_d    = done_q;
    case (state_q)
      IDLE: if (i_start_valid) begin
        state_d   = RUN;
        a_d       = i_data_a;
        b_d       = i_data_b;
        idx_d     = IW'(NSLICE - 1);
        cnt_d     = '0;
        dec_d     = 1'b0;
        less_d    = 1'b0;
        equal_d   = 1'b0;
        greater_d = 1'b0;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        // only the first differing slice may set the verdict
        if (!c_equal && !dec_q) begin
          less_d    = c_less;
          greater_d = ~c_less;
          dec_d     = 1'b1;
        end
        if ((EARLY_EXIT && !c_equal) || idx_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          equal_d = !dec_q && c_equal;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: if (i_done_ready) begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      dec_q     <= 1'b0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      dec_q     <= dec_d;
      less_q    <= less_d;
      equal_q   <= equal_d;
      greater_q <= greater_d;
      done_q    <= done_d;
    end
  end
  assign o_start_ready = state_q == IDLE;
  assign o_busy        = state_q != IDLE;
  assign o_done_valid  = done_q;
  assign o_less        = less_q;
  assign o_equal       = equal_q;
  assign o_greater     = greater_q;
  assign o_slices      = cnt_q;
endmodule

// File: tb/tb_comp_seq_ctrl.sv
// tb_comp_seq_ctrl: scoreboard bench for comp_seq_ctrl with early-exit and constant-time instances
module tb_comp_seq_ctrl;
  typedef struct packed {logic l; logic e; logic g; logic [3:0] s;} res_t;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [15:0] da, db;
  logic        sv [2];
  logic        dr [2];
  logic        sr [2];
  logic        dv [2];
  logic        ls [2];
  logic        eq [2];
  logic        gt [2];
  logic        busy [2];
  logic [3:0]  sl [2];
  res_t        q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  always #5 i_clk = ~i_clk;
  comp_seq_ctrl #(.DATA_WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start_valid(sv[0]), .o_start_ready(sr[0]),
    .i_data_a(da), .i_data_b(db), .o_done_valid(dv[0]), .i_done_ready(dr[0]),
    .o_less(ls[0]), .o_equal(eq[0]), .o_greater(gt[0]), .o_slices(sl[0]), .o_busy(busy[0])
  );
  comp_seq_ctrl #(.DATA_WIDTH(16), .EARLY_EXIT(1'b1)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start_valid(sv[1]), .o_start_ready(sr[1]),
    .i_data_a(da), .i_data_b(db), .o_done_valid(dv[1]), .i_done_ready(dr[1]),
    .o_less(ls[1]), .o_equal(eq[1]), .o_greater(gt[1]), .o_slices(sl[1]), .o_busy(busy[1])
  );
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input bit ee);
    res_t r;
    int   k;
    r.l = a < b;
    r.e = a == b;
    r.g = a > b;
    r.s = 4'd8;
    if (ee && a != b) begin
      k = 0;
      for (int i = 0; i < 8; i++) if (a[2*i +: 2] != b[2*i +: 2]) k = i;
      r.s = 4'(8 - k);
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input int u);
    chk("rst_ready", 32'(sr[u]), 1);
    chk("rst_valid", 32'(dv[u]), 0);
    chk("rst_busy", 32'(busy[u]), 0);
    chk("rst_verdict", {29'd0, ls[u], eq[u], gt[u]}, 0);
    chk("rst_slices", 32'(sl[u]), 0);
  endtask
  task automatic start(input int u, input logic [15:0] a, input logic [15:0] b);
    @(negedge i_clk);
    da    = a;
    db    = b;
    sv[u] = 1'b1;
    chk("start_ready", 32'(sr[u]), 1);
    q.push_back(model(a, b, u == 1));
    @(negedge i_clk);
    sv[u] = 1'b0;
    chk("busy_after_accept", 32'(busy[u]), 1);
  endtask
  task automatic wait_result(input int u);
    int   n;
    res_t r;
    n = 0;
    while (!dv[u] && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    r = q.pop_front();
    chk("latency", n, 32'(r.s));
    chk("less", 32'(ls[u]), 32'(r.l));
    chk("equal", 32'(eq[u]), 32'(r.e));
    chk("greater", 32'(gt[u]), 32'(r.g));
    chk("slices", 32'(sl[u]), 32'(r.s));
  endtask
  task automatic ack(input int u);
    dr[u] = 1'b1;
    @(negedge i_clk);
    dr[u] = 1'b0;
    chk("idle_valid", 32'(dv[u]), 0);
    chk("idle_ready", 32'(sr[u]), 1);
  endtask
  task automatic txn(input int u, input logic [15:0] a, input logic [15:0] b);
    start(u, a, b);
    wait_result(u);
    ack(u);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0;
      dr[i] = 1'b0;
    end
    da      = '0;
    db      = '0;
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    chk_reset(0);
    chk_reset(1);
    i_rst_n = 1'b1;
    txn(1, 16'h8000, 16'h7FFF);
    txn(1, 16'h1234, 16'h1234);
    txn(1, 16'h1230, 16'h1233);
    txn(0, 16'h8000, 16'h7FFF);
    txn(0, 16'h1234, 16'h1234);
    txn(0, 16'h0001, 16'h0F00);
    for (int i = 0; i < 6; i++) txn(i % 2, 16'($urandom), 16'($urandom));
    start(1, 16'h00F0, 16'h00F0);
    wait_result(1);
    for (int i = 0; i < 5; i++) begin
      da    = 16'($urandom);
      db    = 16'($urandom);
      sv[1] = 1'b1;
      @(negedge i_clk);
      chk("bp_ready", 32'(sr[1]), 0);
      chk("bp_valid", 32'(dv[1]), 1);
      chk("bp_verdict", {29'd0, ls[1], eq[1], gt[1]}, 32'b010);
      chk("bp_slices", 32'(sl[1]), 8);
    end
    da    = 16'h0003;
    db    = 16'h0001;
    dr[1] = 1'b1;
    @(negedge i_clk);
    dr[1] = 1'b0;
    chk("bp_release_valid", 32'(dv[1]), 0);
    chk("bp_release_busy", 32'(busy[1]), 0);
    chk("bp_release_ready", 32'(sr[1]), 1);
    q.push_back(model(16'h0003, 16'h0001, 1'b1));
    @(negedge i_clk);
    sv[1] = 1'b0;
    chk("bp_next_busy", 32'(busy[1]), 1);
    wait_result(1);
    ack(1);
    @(negedge i_clk);
    da    = 16'h0001;
    db    = 16'h0002;
    sv[1] = 1'b1;
    @(negedge i_clk);
    sv[1] = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("mid_run_busy", 32'(busy[1]), 1);
    i_rst_n = 1'b0;
    #1;
    chk_reset(1);
    repeat (2) begin
      @(negedge i_clk);
      chk("rst_hold_valid", 32'(dv[1]), 0);
    end
    i_rst_n = 1'b1;
    txn(1, 16'h0005, 16'h0004);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
